// File: rtl/xor_stream_engine.sv
// xor_stream_engine: XORs a byte stream against a repeating key held in an
//   external register file; a load mode writes key bytes into that file.
// Latency: one cycle from input handshake to out_valid; one byte per cycle
//   at full rate.
// Backpressure: in_ready drops whenever the output register is full and
//   out_ready is low, so nothing is lost or duplicated while stalled.
//
// Ports:
//   clk, clr           rising-edge clock, asynchronous active-high clear
//   key_load           level; enters/holds key-load mode
//   key_valid/key_data key byte to write while loading
//   key_len            key length minus 1, captured on start
//   start              one-cycle pulse beginning a message (IDLE only)
//   in_valid/in_data/in_last/in_ready      plaintext stream
//   out_valid/out_data/out_last/out_ready  ciphertext stream
//   rf_we/rf_wa/rf_wd  key register file write port
//   rf_ra/rf_rd        key register file asynchronous read port
//   busy               high in any state other than IDLE
module xor_stream_engine #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         key_load,
  input  logic         key_valid,
  input  logic [B-1:0] key_data,
  input  logic [W-1:0] key_len,
  input  logic         start,
  input  logic         in_valid,
  input  logic [B-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [B-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         rf_we,
  output logic [W-1:0] rf_wa,
  output logic [B-1:0] rf_wd,
  output logic [W-1:0] rf_ra,
  input  logic [B-1:0] rf_rd,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t       state_q,    state_d;
  logic [W-1:0] load_idx_q, load_idx_d;
  logic [W-1:0] key_idx_q,  key_idx_d;
  logic [W-1:0] key_last_q, key_last_d;
  logic         out_valid_q, out_valid_d;
  logic [B-1:0] out_data_q,  out_data_d;
  logic         out_last_q,  out_last_d;

  logic in_hs;
  logic out_hs;

  // The output register can take a new byte when it is empty or being
  // emptied this same cycle; only RUN accepts plaintext.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // Key writes pass straight through while loading; the write data is
  // gated so the port is quiet outside LOAD.
  assign rf_we = (state_q == LOAD) && key_valid;
  assign rf_wa = load_idx_q;
  assign rf_wd = (state_q == LOAD) ? key_data : '0;
  assign rf_ra = key_idx_q;

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    load_idx_d  = load_idx_q;
    key_idx_d   = key_idx_q;
    key_last_d  = key_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        // key_load wins over a simultaneous start
        if (key_load) begin
          state_d    = LOAD;
          load_idx_d = '0;
        end else if (start) begin
          state_d    = RUN;
          key_idx_d  = '0;
          key_last_d = key_len;
        end
      end

      LOAD: begin
        // A byte presented in the cycle key_load falls is still written.
        if (key_valid) begin
          load_idx_d = load_idx_q + W'(1);
        end
        if (!key_load) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (in_hs) begin
          key_idx_d = (key_idx_q == key_last_q) ? '0 : key_idx_q + W'(1);
          if (in_last) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Output register: a fresh byte overrides the clear so back-to-back
    // handshakes keep out_valid high at full rate.
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ rf_rd;
      out_last_d  = in_last;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      load_idx_q  <= '0;
      key_idx_q   <= '0;
      key_last_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      key_idx_q   <= key_idx_d;
      key_last_q  <= key_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_xor_stream_engine.sv
module tb_xor_stream_engine;

  localparam int B = 8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         key_load;
  logic         key_valid;
  logic [B-1:0] key_data;
  logic [W-1:0] key_len;
  logic         start;
  logic         in_valid;
  logic [B-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [B-1:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic         rf_we;
  logic [W-1:0] rf_wa;
  logic [B-1:0] rf_wd;
  logic [W-1:0] rf_ra;
  logic [B-1:0] rf_rd;
  logic         busy;

  xor_stream_engine #(.B(B), .W(W)) dut (
    .clk(clk), .clr(clr),
    .key_load(key_load), .key_valid(key_valid), .key_data(key_data),
    .key_len(key_len), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Key register file: synchronous write, asynchronous read.
  logic [B-1:0] rf_mem [2**W] = '{default: 8'h00};
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;
  assign rf_rd = rf_mem[rf_ra];

  int vec_cnt = 0;
  int err_cnt = 0;
  int stall_cycles = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0] din;
    logic       last;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!clr && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_output: got 0x%0h, expected no byte at %0t", out_data, $time);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", {24'h0, out_data}, {24'h0, e.d});
        chk("out_last", {31'h0, out_last}, {31'h0, e.l});
      end
    end
  end

  // Present one byte, wait (bounded) for acceptance, record the expected
  // ciphertext, and return one step after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
      stall_cycles++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
    end else begin
      sb_q.push_back('{d: e, l: l});
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic do_start(input logic [W-1:0] len);
    key_len = len;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_rf_ra", {28'h0, rf_ra}, 32'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_to_idle", {31'h0, busy}, 32'h0);
    chk("scoreboard_empty", sb_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] kw;

    tbl[0]  = '{8'h00, 1'b0, 8'h11};
    tbl[1]  = '{8'h00, 1'b0, 8'h22};
    tbl[2]  = '{8'h00, 1'b0, 8'h33};
    tbl[3]  = '{8'h00, 1'b0, 8'h44};
    tbl[4]  = '{8'h00, 1'b0, 8'h11};
    tbl[5]  = '{8'h00, 1'b1, 8'h22};
    tbl[6]  = '{8'h00, 1'b0, 8'h11};
    tbl[7]  = '{8'h01, 1'b0, 8'h23};
    tbl[8]  = '{8'h02, 1'b0, 8'h31};
    tbl[9]  = '{8'h03, 1'b0, 8'h47};
    tbl[10] = '{8'h04, 1'b0, 8'h15};
    tbl[11] = '{8'h05, 1'b1, 8'h27};

    // Reset with busy-looking inputs: clear must hold everything quiet.
    clr = 1'b1; key_load = 1'b1; key_valid = 1'b1; key_data = 8'h77;
    key_len = '0; start = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1;
    #22;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data",  {24'h0, out_data},  32'h0);
    chk("rst_out_last",  {31'h0, out_last},  32'h0);
    chk("rst_busy",      {31'h0, busy},      32'h0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h0);
    chk("rst_rf_we",     {31'h0, rf_we},     32'h0);
    chk("rst_rf_wa",     {28'h0, rf_wa},     32'h0);
    chk("rst_rf_wd",     {24'h0, rf_wd},     32'h0);
    chk("rst_rf_ra",     {28'h0, rf_ra},     32'h0);
    key_load = 1'b0; key_valid = 1'b0; key_data = '0; start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", {31'h0, busy}, 32'h0);

    // Key load of four bytes.
    kw = 32'h44332211;
    key_load = 1'b1;
    @(posedge clk); #1;
    chk("load_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_data  = kw[8*i +: 8];
      #1;
      chk("load_rf_we", {31'h0, rf_we}, 32'h1);
      chk("load_rf_wa", {28'h0, rf_wa}, i);
      chk("load_rf_wd", {24'h0, rf_wd}, {24'h0, kw[8*i +: 8]});
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    key_load  = 1'b0;
    #1;
    chk("load_we_off", {31'h0, rf_we}, 32'h0);
    chk("load_hold_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    chk("load_exit_idle", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 4; i++) chk("key_stored", {24'h0, rf_mem[i]}, {24'h0, kw[8*i +: 8]});

    // Table-driven messages, key_len=3, full rate. A stray start in the
    // middle of the second message must not restart the key.
    for (int m = 0; m < 2; m++) begin
      do_start(4'd3);
      stall_cycles = 0;
      for (int i = 0; i < 6; i++) begin
        vec_t v;
        v = tbl[m*6 + i];
        if (m == 1 && i == 3) start = 1'b1;
        send(v.din, v.last, v.dout);
        start = 1'b0;
      end
      chk("full_rate_stalls", stall_cycles, 32'h0);
      wait_idle();
    end

    // Downstream stall for three cycles mid-message.
    do_start(4'd3);
    send(8'hA0, 1'b0, 8'hB1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    in_last   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready",  {31'h0, in_ready},  32'h0);
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_out_data",  {24'h0, out_data},  32'hB1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'hA1, 1'b0, 8'h83);
    send(8'hA2, 1'b1, 8'h91);
    wait_idle();

    // Clear during RUN with a byte pending.
    do_start(4'd3);
    send(8'h00, 1'b0, 8'h11);
    out_ready = 1'b0;
    #1;
    chk("pre_clr_out_valid", {31'h0, out_valid}, 32'h1);
    clr = 1'b1;
    #1;
    chk("clr_out_valid", {31'h0, out_valid}, 32'h0);
    chk("clr_busy",      {31'h0, busy},      32'h0);
    chk("clr_in_ready",  {31'h0, in_ready},  32'h0);
    chk("clr_out_data",  {24'h0, out_data},  32'h0);
    sb_q.delete();
    #2;
    clr = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    do_start(4'd3);
    send(8'h00, 1'b1, 8'h11);
    wait_idle();

    // key_load and start together: load wins, no ciphertext.
    key_load = 1'b1;
    start    = 1'b1;
    key_len  = 4'd3;
    @(posedge clk); #1;
    key_load = 1'b0;
    start    = 1'b0;
    #1;
    chk("prio_busy_load",  {31'h0, busy},      32'h1);
    chk("prio_in_ready",   {31'h0, in_ready},  32'h0);
    chk("prio_out_valid",  {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("prio_back_idle",  {31'h0, busy},      32'h0);
    @(posedge clk); #1;
    chk("prio_no_output",  {31'h0, out_valid}, 32'h0);

    // Single-byte key, written in the same cycle key_load falls.
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load  = 1'b0;
    key_valid = 1'b1;
    key_data  = 8'hA5;
    #1;
    chk("late_byte_we", {31'h0, rf_we}, 32'h1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("late_byte_idle", {31'h0, busy}, 32'h0);
    chk("late_byte_stored", {24'h0, rf_mem[0]}, 32'hA5);
    do_start(4'd0);
    send(8'hFF, 1'b0, 8'h5A);
    send(8'h5A, 1'b1, 8'hFF);
    wait_idle();
    chk("idle_in_ready", {31'h0, in_ready}, 32'h0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
